// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver.
//   state_e    : receiver FSM state encodings
//   MAX_DATA_W : widest supported data word
//   CNT_W      : bit counter width, sized for the widest supported word
package serial_frame_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } state_e;

    localparam int MAX_DATA_W = 16;
    // $clog2(DATA_W+1) evaluated at the largest legal DATA_W, so it fits every width.
    localparam int CNT_W = $clog2(MAX_DATA_W + 1);

endpackage

// File: rtl/serial_frame_rx_out_buf.sv
// One-entry valid/ready holding register for received words.
//   clk, clr  : clock, synchronous active-high reset
//   load_i    : a good word is available this cycle
//   data_i    : the good word
//   ready_i   : consumer accepts data_o when valid_o & ready_i
//   data_o    : held word
//   valid_o   : data_o holds an unconsumed word
//   overrun_o : one-cycle pulse, a good word was dropped because the buffer was full
module frame_out_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              overrun_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (load_i) begin
                // A word leaving on this same edge frees the slot for the new one.
                if (!valid_q || ready_i) begin
                    data_q  <= data_i;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit 0, DATA_W data bits LSB first,
// optional parity bit, stop bit 1. Line idles at 1.
//   clk, clr   : clock, synchronous active-high reset
//   din        : serial line, sampled only when bit_en=1
//   bit_en     : bit strobe
//   out_data   : received word, held while out_valid=1
//   out_valid  : out_data holds an unconsumed word
//   out_ready  : consumer handshake
//   parity_err : one-cycle pulse, parity mismatch, frame dropped
//   frame_err  : one-cycle pulse, stop bit was 0, frame dropped
//   overrun    : one-cycle pulse, good frame lost to a full buffer
//   busy       : FSM is not idle
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              din,
    input  logic              bit_en,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic             PAR_ODD  = (PARITY_ODD != 0);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_bad_q;
    logic              parity_err_q;
    logic              frame_err_q;
    logic              good_frame;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (bit_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!din) begin
                            state_q   <= ST_DATA;
                            cnt_q     <= '0;
                            par_bad_q <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        // Shifting in from the top leaves the first (LSB) bit at bit 0.
                        shift_q <= {din, shift_q[DATA_W-1:1]};
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT)
                            state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                    ST_PARITY: begin
                        par_bad_q <= (din != ((^shift_q) ^ PAR_ODD));
                        state_q   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (din) begin
                            parity_err_q <= par_bad_q;
                            state_q      <= ST_IDLE;
                        end else begin
                            // Framing error wins; a pending parity mismatch is not reported.
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end
                    ST_BREAK: begin
                        if (din)
                            state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Good frame is offered to the buffer on the edge that samples the stop bit.
    assign good_frame = bit_en && (state_q == ST_STOP) && din && !par_bad_q;

    frame_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .clr       (clr),
        .load_i    (good_frame),
        .data_i    (shift_q),
        .ready_i   (out_ready),
        .data_o    (out_data),
        .valid_o   (out_valid),
        .overrun_o (overrun)
    );

    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          din;
    logic          bit_en;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int parity_cnt  = 0;
    int frame_cnt   = 0;
    int overrun_cnt = 0;
    int hs_cnt      = 0;

    logic [DW-1:0] exp_q[$];

    serial_frame_rx #(
        .DATA_W     (DW),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .din        (din),
        .bit_en     (bit_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every handshake pops the next expected word.
    always @(negedge clk) begin
        if (!clr) begin
            if (parity_err) parity_cnt++;
            if (frame_err)  frame_cnt++;
            if (overrun)    overrun_cnt++;
            if (out_valid && out_ready) begin
                logic [DW-1:0] exp_w;
                hs_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $error("FAIL handshake_unexpected observed=%0h expected=none", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    assert (out_data === exp_w)
                    else begin
                        bad++;
                        $error("FAIL handshake_data observed=%0h expected=%0h", out_data, exp_w);
                    end
                end
            end
        end
    end

    // gap cycles with bit_en=0 (din driven to the opposite value) precede each strobed bit.
    task automatic send_bit(input logic b, input int gap);
        repeat (gap) begin
            bit_en = 1'b0;
            din    = ~b;
            @(posedge clk);
            #1;
        end
        din    = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        din    = 1'b1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic bad_par,
                              input logic stop, input int gap);
        logic p;
        send_bit(1'b0, gap);
        for (int i = 0; i < DW; i++) send_bit(d[i], gap);
        p = (^d) ^ bad_par;
        send_bit(p, gap);
        send_bit(stop, gap);
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b1, 0);
    endtask

    initial begin
        logic [DW-1:0] w;
        clr       = 1'b1;
        din       = 1'b1;
        bit_en    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_errs", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        idle(2);

        // Good frame 0x4A, one-cycle valid
        exp_q.push_back(8'h4A);
        send_frame(8'h4A, 1'b0, 1'b1, 0);
        check("s1_valid", 32'(out_valid), 32'd1);
        check("s1_data", 32'(out_data), 32'h4A);
        check("s1_errs", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        @(posedge clk);
        #1;
        check("s1_valid_drop", 32'(out_valid), 32'd0);
        idle(1);

        // Bad parity, then good 0x55
        send_frame(8'h4A, 1'b1, 1'b1, 0);
        check("s2_parity_err", 32'(parity_err), 32'd1);
        check("s2_valid", 32'(out_valid), 32'd0);
        idle(1);
        check("s2_parity_clear", 32'(parity_err), 32'd0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b1, 0);
        check("s2_data", 32'(out_data), 32'h55);
        check("s2_valid2", 32'(out_valid), 32'd1);
        idle(2);

        // Framing error, break, then 0x0F
        send_frame(8'hFF, 1'b0, 1'b0, 0);
        check("s3_frame_err", 32'(frame_err), 32'd1);
        check("s3_parity_err", 32'(parity_err), 32'd0);
        check("s3_busy_break", 32'(busy), 32'd1);
        repeat (5) send_bit(1'b0, 0);
        check("s3_still_break", 32'(busy), 32'd1);
        check("s3_no_valid", 32'(out_valid), 32'd0);
        send_bit(1'b1, 0);
        check("s3_idle", 32'(busy), 32'd0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b1, 0);
        check("s3_data", 32'(out_data), 32'h0F);
        idle(2);

        // Overrun with consumer stalled
        out_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1, 0);
        idle(1);
        check("s4_hold_valid", 32'(out_valid), 32'd1);
        send_frame(8'h22, 1'b0, 1'b1, 0);
        check("s4_overrun", 32'(overrun), 32'd1);
        check("s4_data_kept", 32'(out_data), 32'h11);
        check("s4_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("s4_valid_drop", 32'(out_valid), 32'd0);
        check("s4_overrun_clear", 32'(overrun), 32'd0);
        idle(1);

        // Bit strobe 1 in 4
        exp_q.push_back(8'h4A);
        send_frame(8'h4A, 1'b0, 1'b1, 3);
        check("s5_valid", 32'(out_valid), 32'd1);
        check("s5_data", 32'(out_data), 32'h4A);
        check("s5_errs", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        @(posedge clk);
        #1;
        check("s5_valid_drop", 32'(out_valid), 32'd0);
        idle(1);

        // clr mid-frame after 4 data bits
        w = 8'hA5;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(w[i], 0);
        check("s6_busy_mid", 32'(busy), 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("s6_busy_clr", 32'(busy), 32'd0);
        check("s6_errs", {29'd0, parity_err, frame_err, overrun}, 32'd0);
        idle(2);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        check("s6_data", 32'(out_data), 32'h3C);
        check("s6_valid", 32'(out_valid), 32'd1);
        idle(3);

        // Totals
        check("parity_pulses", 32'(parity_cnt), 32'd1);
        check("frame_pulses", 32'(frame_cnt), 32'd1);
        check("overrun_pulses", 32'(overrun_cnt), 32'd1);
        check("handshakes", 32'(hs_cnt), 32'd6);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
